// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the RV32I 5-stage pipeline registers.
//   XLEN        : datapath / PC width
//   CTRL_W      : packed control width, must equal $bits(id_ex_ctrl_t)
//   hz_state_e  : ID/EX hazard FSM encoding (3 is unused and decodes to RUN)
//   id_ex_ctrl_t: decoded control bundle carried from ID into EX
//   BUBBLE_CTRL : control word of a NOP bubble (all zeros, no side effects)
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 11;

    typedef enum logic [1:0] {
        HZ_RUN       = 2'd0,
        HZ_LU_BUBBLE = 2'd1,
        HZ_HOLD      = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic       RegWrite;   // [10]
        logic       MemRead;    // [9]
        logic       MemWrite;   // [8]
        logic       MemToReg;   // [7]
        logic       ALUSrc;     // [6]
        logic       Branch;     // [5]
        logic       Jump;       // [4]
        logic [3:0] ALUOp;      // [3:0]
    } id_ex_ctrl_t;

    // Bit position of MemRead inside the packed control word.
    localparam int CTRL_MEMREAD_BIT = 9;

    localparam id_ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard equation. A load sitting in EX whose
// destination is read by the instruction in ID cannot be forwarded in time,
// so the ID instruction must wait one cycle.
// Ports:
//   ex_valid_i, ex_memread_i, ex_rd_i : instruction currently in EX
//   id_valid_i, id_rs1_i, id_rs2_i    : instruction currently in ID
//   id_uses_rs1_i, id_uses_rs2_i      : ID instruction actually reads operand
//   lu_o                              : load-use hazard present
// ---------------------------------------------------------------------------
module load_use_detect (
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    output logic       lu_o
);

    logic rs1_hit, rs2_hit;

    assign rs1_hit = id_uses_rs1_i & (ex_rd_i == id_rs1_i);
    assign rs2_hit = id_uses_rs2_i & (ex_rd_i == id_rs2_i);

    // x0 is never a real destination, so a load to x0 cannot create a hazard.
    assign lu_o = ex_valid_i & ex_memread_i & (ex_rd_i != 5'd0) & id_valid_i
                & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register with load-use bubble insertion, global freeze and
// branch-flush handling (including a flush that arrives while frozen, which
// is remembered in a pending flag and applied when the freeze lifts).
//
// Optional feature macro: ID_EX_PERF_CNT_EN
//   defined   : Perf_Bubbles / Perf_Flushes / Perf_Freeze are live 32-bit
//               wrapping counters, cleared by rst
//   undefined : the same ports exist but are tied to zero, no counter flops
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   Stall_in                  : global freeze (IM/DM wait), holds everything
//   Flush                     : taken branch/jump from EX, kill ID instruction
//   IF_ID_*, Uses_RS*, ID_Ctrl: instruction presented by the ID stage
//   Data_rs1, Data_rs2        : operands already forwarded in ID
//   PC_Write, IF_ID_Write     : 0 while a load-use bubble is being inserted
//   ID_EX_*                   : registered instruction for EX
//   Hz_State                  : hazard FSM state (RUN/LU_BUBBLE/HOLD), debug
//   Perf_*                    : optional performance counters
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall_in,
    input  logic              Flush,
    input  logic              IF_ID_Valid,
    input  logic [XLEN-1:0]   IF_ID_PC,
    input  logic [XLEN-1:0]   IF_ID_Imm,
    input  logic [4:0]        IF_ID_RS1,
    input  logic [4:0]        IF_ID_RS2,
    input  logic [4:0]        IF_ID_Rd,
    input  logic              Uses_RS1,
    input  logic              Uses_RS2,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic [XLEN-1:0]   Data_rs1,
    input  logic [XLEN-1:0]   Data_rs2,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              ID_EX_Valid,
    output logic [XLEN-1:0]   ID_EX_PC,
    output logic [XLEN-1:0]   ID_EX_Imm,
    output logic [XLEN-1:0]   ID_EX_Data_rs1,
    output logic [XLEN-1:0]   ID_EX_Data_rs2,
    output logic [4:0]        ID_EX_RS1,
    output logic [4:0]        ID_EX_RS2,
    output logic [4:0]        ID_EX_Rd,
    output logic [CTRL_W-1:0] ID_EX_Ctrl,
    output logic [1:0]        Hz_State,
    output logic [31:0]       Perf_Bubbles,
    output logic [31:0]       Perf_Flushes,
    output logic [31:0]       Perf_Freeze
);

    import pipe_pkg::*;

    localparam logic [1:0] ST_RUN       = 2'(HZ_RUN);
    localparam logic [1:0] ST_LU_BUBBLE = 2'(HZ_LU_BUBBLE);
    localparam logic [1:0] ST_HOLD      = 2'(HZ_HOLD);

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL_W = CTRL_W'(BUBBLE_CTRL);

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q,    pc_d;
    logic [XLEN-1:0]   imm_q,   imm_d;
    logic [XLEN-1:0]   d1_q,    d1_d;
    logic [XLEN-1:0]   d2_q,    d2_d;
    logic [4:0]        rs1_q,   rs1_d;
    logic [4:0]        rs2_q,   rs2_d;
    logic [4:0]        rd_q,    rd_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [1:0]        state_q, state_d;
    logic              pend_q,  pend_d;   // flush seen while frozen

    logic lu;
    logic flush_now;
    logic take_lu;

    load_use_detect u_lu (
        .ex_valid_i    (valid_q),
        .ex_memread_i  (ctrl_q[CTRL_MEMREAD_BIT]),
        .ex_rd_i       (rd_q),
        .id_valid_i    (IF_ID_Valid),
        .id_rs1_i      (IF_ID_RS1),
        .id_rs2_i      (IF_ID_RS2),
        .id_uses_rs1_i (Uses_RS1),
        .id_uses_rs2_i (Uses_RS2),
        .lu_o          (lu)
    );

    assign flush_now = Flush | pend_q;
    assign take_lu   = lu & ~Stall_in & ~flush_now;

    // Stall_in is deliberately not folded in here: upstream freezes on it
    // directly. rst forces the enables high because lu is built from
    // registers that are not yet cleared during the reset cycle.
    assign PC_Write    = rst | ~take_lu;
    assign IF_ID_Write = rst | ~take_lu;

    // -----------------------------------------------------------------------
    // Next-state: freeze > flush (live or pending) > load-use bubble > capture
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        state_d = state_q;
        pend_d  = pend_q;

        if (Stall_in) begin
            pend_d  = pend_q | Flush;
            state_d = ST_HOLD;
        end else if (flush_now | lu) begin
            valid_d = 1'b0;
            pc_d    = '0;
            imm_d   = '0;
            d1_d    = '0;
            d2_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            ctrl_d  = BUBBLE_CTRL_W;
            pend_d  = 1'b0;
            state_d = flush_now ? ST_RUN : ST_LU_BUBBLE;
        end else begin
            valid_d = IF_ID_Valid;
            pc_d    = IF_ID_PC;
            imm_d   = IF_ID_Imm;
            d1_d    = Data_rs1;
            d2_d    = Data_rs2;
            rs1_d   = IF_ID_RS1;
            rs2_d   = IF_ID_RS2;
            rd_d    = IF_ID_Rd;
            ctrl_d  = ID_Ctrl;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign ID_EX_Valid    = valid_q;
    assign ID_EX_PC       = pc_q;
    assign ID_EX_Imm      = imm_q;
    assign ID_EX_Data_rs1 = d1_q;
    assign ID_EX_Data_rs2 = d2_q;
    assign ID_EX_RS1      = rs1_q;
    assign ID_EX_RS2      = rs2_q;
    assign ID_EX_Rd       = rd_q;
    assign ID_EX_Ctrl     = ctrl_q;
    // Encoding 3 is unreachable; report it as RUN if it ever shows up.
    assign Hz_State       = (state_q == 2'd3) ? ST_RUN : state_q;

    // The bubble slot holds no load, so a second load-use right behind the
    // first means the EX contents were corrupted.
    a_no_double_lu : assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_LU_BUBBLE) |-> !lu);

    // -----------------------------------------------------------------------
    // Optional performance counters
    // -----------------------------------------------------------------------
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bub_cnt_q, fl_cnt_q, frz_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bub_cnt_q <= '0;
            fl_cnt_q  <= '0;
            frz_cnt_q <= '0;
        end else begin
            if (Stall_in)
                frz_cnt_q <= frz_cnt_q + 32'd1;
            // A pending flush is counted when its bubble is loaded, so a
            // flush is counted exactly once whether it was deferred or not.
            if (!Stall_in && flush_now)
                fl_cnt_q <= fl_cnt_q + 32'd1;
            if (take_lu)
                bub_cnt_q <= bub_cnt_q + 32'd1;
        end
    end

    assign Perf_Bubbles = bub_cnt_q;
    assign Perf_Flushes = fl_cnt_q;
    assign Perf_Freeze  = frz_cnt_q;
`else
    assign Perf_Bubbles = '0;
    assign Perf_Flushes = '0;
    assign Perf_Freeze  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Directed-vector bench for id_ex_stage_reg: plain capture, load-use bubble,
// suppressed load-use, flush vs load-use, freeze with pending flush, and
// reset during a freeze. Optional counter checks follow ID_EX_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 11;

    // Control words: add = RegWrite|ALUOp=2, lw = RegWrite|MemRead|MemToReg|ALUSrc
    localparam logic [CTRL_W-1:0] C_ADD = 11'h402;
    localparam logic [CTRL_W-1:0] C_LW  = 11'h6C0;

    logic              clk = 1'b0;
    logic              rst;
    logic              Stall_in, Flush;
    logic              IF_ID_Valid;
    logic [XLEN-1:0]   IF_ID_PC, IF_ID_Imm;
    logic [4:0]        IF_ID_RS1, IF_ID_RS2, IF_ID_Rd;
    logic              Uses_RS1, Uses_RS2;
    logic [CTRL_W-1:0] ID_Ctrl;
    logic [XLEN-1:0]   Data_rs1, Data_rs2;
    logic              PC_Write, IF_ID_Write, ID_EX_Valid;
    logic [XLEN-1:0]   ID_EX_PC, ID_EX_Imm, ID_EX_Data_rs1, ID_EX_Data_rs2;
    logic [4:0]        ID_EX_RS1, ID_EX_RS2, ID_EX_Rd;
    logic [CTRL_W-1:0] ID_EX_Ctrl;
    logic [1:0]        Hz_State;
    logic [31:0]       Perf_Bubbles, Perf_Flushes, Perf_Freeze;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .Stall_in       (Stall_in),
        .Flush          (Flush),
        .IF_ID_Valid    (IF_ID_Valid),
        .IF_ID_PC       (IF_ID_PC),
        .IF_ID_Imm      (IF_ID_Imm),
        .IF_ID_RS1      (IF_ID_RS1),
        .IF_ID_RS2      (IF_ID_RS2),
        .IF_ID_Rd       (IF_ID_Rd),
        .Uses_RS1       (Uses_RS1),
        .Uses_RS2       (Uses_RS2),
        .ID_Ctrl        (ID_Ctrl),
        .Data_rs1       (Data_rs1),
        .Data_rs2       (Data_rs2),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .ID_EX_Valid    (ID_EX_Valid),
        .ID_EX_PC       (ID_EX_PC),
        .ID_EX_Imm      (ID_EX_Imm),
        .ID_EX_Data_rs1 (ID_EX_Data_rs1),
        .ID_EX_Data_rs2 (ID_EX_Data_rs2),
        .ID_EX_RS1      (ID_EX_RS1),
        .ID_EX_RS2      (ID_EX_RS2),
        .ID_EX_Rd       (ID_EX_Rd),
        .ID_EX_Ctrl     (ID_EX_Ctrl),
        .Hz_State       (Hz_State),
        .Perf_Bubbles   (Perf_Bubbles),
        .Perf_Flushes   (Perf_Flushes),
        .Perf_Freeze    (Perf_Freeze)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; inputs are changed and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                         input logic u2, input logic [CTRL_W-1:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        IF_ID_Valid = v;   IF_ID_PC  = pc;  IF_ID_Imm = pc + 32'h10;
        IF_ID_RS1   = rs1; IF_ID_RS2 = rs2; IF_ID_Rd  = rd;
        Uses_RS1    = u1;  Uses_RS2  = u2;  ID_Ctrl   = c;
        Data_rs1    = a;   Data_rs2  = b;
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 64'(ID_EX_Valid), 64'd0);
        chk({tag, ".pc"},    64'(ID_EX_PC),    64'd0);
        chk({tag, ".imm"},   64'(ID_EX_Imm),   64'd0);
        chk({tag, ".d1"},    64'(ID_EX_Data_rs1), 64'd0);
        chk({tag, ".d2"},    64'(ID_EX_Data_rs2), 64'd0);
        chk({tag, ".rs"},    64'({ID_EX_RS1, ID_EX_RS2, ID_EX_Rd}), 64'd0);
        chk({tag, ".ctrl"},  64'(ID_EX_Ctrl),  64'd0);
    endtask

    initial begin
        rst = 1'b1; Stall_in = 1'b0; Flush = 1'b0;
        instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, '0, 32'h0, 32'h0);

        // Reset
        step();
        step();
        chk("rst.pcw",  64'(PC_Write), 64'd1);
        chk("rst.ifw",  64'(IF_ID_Write), 64'd1);
        chk_zero("rst");
        chk("rst.hz",   64'(Hz_State), 64'd0);
        rst = 1'b0;

        // 1. Plain pipeline: add x5, x1, x2 at 0x100
        instr(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, C_ADD, 32'd7, 32'd9);
        chk("t1.pcw_pre", 64'(PC_Write), 64'd1);
        step();
        chk("t1.valid", 64'(ID_EX_Valid), 64'd1);
        chk("t1.pc",    64'(ID_EX_PC), 64'h100);
        chk("t1.imm",   64'(ID_EX_Imm), 64'h110);
        chk("t1.d1",    64'(ID_EX_Data_rs1), 64'd7);
        chk("t1.d2",    64'(ID_EX_Data_rs2), 64'd9);
        chk("t1.rd",    64'(ID_EX_Rd), 64'd5);
        chk("t1.ctrl",  64'(ID_EX_Ctrl), 64'(C_ADD));
        chk("t1.pcw",   64'(PC_Write), 64'd1);

        // 2. Load-use: lw x6 in EX, add x8, x6, x7 in ID
        instr(1'b1, 32'h104, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, C_LW, 32'd0, 32'd0);
        step();
        instr(1'b1, 32'h108, 5'd6, 5'd7, 5'd8, 1'b1, 1'b1, C_ADD, 32'd11, 32'd22);
        chk("t2.pcw",   64'(PC_Write), 64'd0);
        chk("t2.ifw",   64'(IF_ID_Write), 64'd0);
        step();
        chk_zero("t2.bub");
        chk("t2.hz",    64'(Hz_State), 64'd1);
        chk("t2.pcw_after", 64'(PC_Write), 64'd1);
        step();
        chk("t2.valid", 64'(ID_EX_Valid), 64'd1);
        chk("t2.pc",    64'(ID_EX_PC), 64'h108);
        chk("t2.rd",    64'(ID_EX_Rd), 64'd8);
        chk("t2.d1",    64'(ID_EX_Data_rs1), 64'd11);
        chk("t2.hz_run", 64'(Hz_State), 64'd0);

        // 3a. Load-use suppressed by Uses_RS1=0
        instr(1'b1, 32'h10C, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, C_LW, 32'd0, 32'd0);
        step();
        instr(1'b1, 32'h110, 5'd6, 5'd7, 5'd9, 1'b0, 1'b1, C_ADD, 32'd1, 32'd2);
        chk("t3a.pcw", 64'(PC_Write), 64'd1);
        step();
        chk("t3a.pc",  64'(ID_EX_PC), 64'h110);
        chk("t3a.hz",  64'(Hz_State), 64'd0);

        // 3b. Load-use suppressed by a load to x0
        instr(1'b1, 32'h114, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LW, 32'd0, 32'd0);
        step();
        instr(1'b1, 32'h118, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, C_ADD, 32'd3, 32'd4);
        chk("t3b.ifw", 64'(IF_ID_Write), 64'd1);
        step();
        chk("t3b.valid", 64'(ID_EX_Valid), 64'd1);
        chk("t3b.pc",  64'(ID_EX_PC), 64'h118);

        // 4. Flush in the same cycle as load-use
        instr(1'b1, 32'h11C, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, C_LW, 32'd0, 32'd0);
        step();
        instr(1'b1, 32'h120, 5'd6, 5'd7, 5'd8, 1'b1, 1'b1, C_ADD, 32'd5, 32'd6);
        Flush = 1'b1;
        #1;
        chk("t4.pcw",  64'(PC_Write), 64'd1);
        step();
        Flush = 1'b0;
        chk_zero("t4.bub");
        chk("t4.hz",   64'(Hz_State), 64'd0);

        // 5. Freeze with a flush pulsed on its 2nd cycle (counters from reset)
        rst = 1'b1;
        step();
        rst = 1'b0;
        instr(1'b1, 32'h200, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, C_ADD, 32'd3, 32'd4);
        step();
        chk("t5.pc0",  64'(ID_EX_PC), 64'h200);
        instr(1'b1, 32'h204, 5'd3, 5'd4, 5'd10, 1'b1, 1'b1, C_ADD, 32'd8, 32'd8);
        Stall_in = 1'b1;
        step();
        chk("t5.f1.pc", 64'(ID_EX_PC), 64'h200);
        chk("t5.f1.hz", 64'(Hz_State), 64'd2);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("t5.f2.pc", 64'(ID_EX_PC), 64'h200);
        chk("t5.f2.d1", 64'(ID_EX_Data_rs1), 64'd3);
        chk("t5.f2.hz", 64'(Hz_State), 64'd2);
        step();
        chk("t5.f3.valid", 64'(ID_EX_Valid), 64'd1);
        chk("t5.f3.rd", 64'(ID_EX_Rd), 64'd9);
        Stall_in = 1'b0;
        #1;
        step();
        chk_zero("t5.bub");
        chk("t5.hz",   64'(Hz_State), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("t5.pf_fl",  64'(Perf_Flushes), 64'd1);
        chk("t5.pf_frz", 64'(Perf_Freeze),  64'd3);
        chk("t5.pf_bub", 64'(Perf_Bubbles), 64'd0);
`else
        chk("t5.pf_tied", 64'({Perf_Bubbles, Perf_Flushes} | 64'(Perf_Freeze)), 64'd0);
`endif
        step();
        chk("t5.next.pc", 64'(ID_EX_PC), 64'h204);
        chk("t5.next.valid", 64'(ID_EX_Valid), 64'd1);

        // 6. Reset during HOLD with a pending flush
        Stall_in = 1'b1;
        Flush    = 1'b1;
        step();
        Flush = 1'b0;
        chk("t6.hold", 64'(Hz_State), 64'd2);
        rst = 1'b1;
        #1;
        chk("t6.rst_pcw", 64'(PC_Write), 64'd1);
        step();
        chk_zero("t6.rst");
        chk("t6.hz",   64'(Hz_State), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("t6.pf_frz", 64'(Perf_Freeze), 64'd0);
        chk("t6.pf_fl",  64'(Perf_Flushes), 64'd0);
`endif
        rst      = 1'b0;
        Stall_in = 1'b0;
        instr(1'b1, 32'h300, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, C_ADD, 32'hAA, 32'hBB);
        step();
        chk("t6.valid", 64'(ID_EX_Valid), 64'd1);
        chk("t6.pc",    64'(ID_EX_PC), 64'h300);
        chk("t6.d2",    64'(ID_EX_Data_rs2), 64'hBB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register for the 5-stage RV32I core. It sits directly downstream of the ID-stage forwarding mux and captures the forwarded Data_rs1/Data_rs2, the decoded controls and the instruction fields. It detects load-use hazards, inserts one-cycle bubbles and freezes PC and IF/ID during them. It also honours a global memory-wait freeze and a branch flush from EX, including a flush that arrives during a freeze.

Parameters:
XLEN, 32, datapath and PC width
CTRL_W, 11, packed control width (layout fixed in package)

Ports:
clk  input  1  core clock; one clock domain; all state updates on rising edge
rst  input  1  synchronous, active-high reset
Stall_in  input  1  global freeze (IM/DM wait)
Flush  input  1  taken branch/jump resolved in EX; kill the instruction in ID
IF_ID_Valid  input  1  IF/ID holds a real instruction
IF_ID_PC  input  XLEN  PC of the ID instruction
IF_ID_Imm  input  XLEN  sign-extended immediate
IF_ID_RS1, IF_ID_RS2, IF_ID_Rd  input  5 each  register indices
Uses_RS1, Uses_RS2  input  1 each  instruction reads the operand
ID_Ctrl  input  CTRL_W  decoded controls
Data_rs1, Data_rs2  input  XLEN each  forwarded operands from ID forwarding
PC_Write  output  1  1 = PC may advance
IF_ID_Write  output  1  1 = IF/ID may load
ID_EX_Valid  output  1  EX holds a real instruction
ID_EX_PC, ID_EX_Imm, ID_EX_Data_rs1, ID_EX_Data_rs2  output  XLEN each
ID_EX_RS1, ID_EX_RS2, ID_EX_Rd  output  5 each
ID_EX_Ctrl  output  CTRL_W
Hz_State  output  2  current FSM state (debug)

Behaviour:
- Reset (rst=1 at edge): all registered outputs 0, state RUN, pending-flush flag 0. PC_Write and IF_ID_Write are combinational; while rst is asserted they are 1.
- Load-use hazard LU = ID_EX_Valid & Ctrl.MemRead & ID_EX_Rd!=0 & IF_ID_Valid & ((Uses_RS1 & ID_EX_Rd==IF_ID_RS1) | (Uses_RS2 & ID_EX_Rd==IF_ID_RS2)).
- A bubble sets Valid=0 and zeroes Ctrl, PC, Imm, Data, RS and Rd fields.
- Per-edge priority:
  1. rst: reset as above.
  2. Stall_in: hold all registers. If Flush=1, set pending=1. State becomes HOLD.
  3. Flush | pending: load a bubble, clear pending, state RUN.
  4. LU: load a bubble, state LU_BUBBLE.
  5. Otherwise: capture all inputs; Valid=IF_ID_Valid; state RUN.
- Combinational stall outputs: PC_Write = IF_ID_Write = ~(LU & ~Stall_in & ~Flush & ~pending).
- Stall_in does not gate PC_Write/IF_ID_Write; upstream applies Stall_in itself.
- FSM: RUN=0, LU_BUBBLE=1, HOLD=2 (3 unused, decodes to RUN).
  - LU_BUBBLE lasts exactly one cycle. The producing load then sits in MEM/WB, so LU is naturally false.
  - A second back-to-back LU in LU_BUBBLE is a design error and is flagged by an assertion.
- Latency: 1 cycle from ID inputs to ID_EX_* outputs. Data is captured as presented, and forwarding is not re-evaluated.
- Flush and LU in the same cycle: Flush wins and no stall is raised.
- Stall_in and LU together: hold; LU is re-evaluated when Stall_in drops.
- Reset mid-stall: pending is cleared and the state returns to RUN.

Optional Feature:
ID_EX_PERF_CNT_EN:
- Defined: adds 32-bit outputs Perf_Bubbles (LU bubbles), Perf_Flushes (flush bubbles, each counted once, including pending ones) and Perf_Freeze (cycles with Stall_in=1).
- Counters are reset by rst and wrap at 2^32.
- Not defined: ports present but tied 0, with no counter flops.

Decomposition:
- Package pipe_pkg: XLEN, CTRL_W, the hz_state_e enum and the id_ex_ctrl_t packed struct.
  - Struct bit order: RegWrite[10], MemRead[9], MemWrite[8], MemToReg[7], ALUSrc[6], Branch[5], Jump[4], ALUOp[3:0].
  - The BUBBLE_CTRL constant is all zeros.
- One sub-module, load_use_detect: the combinational LU equation, reused by the future EX hazard checker.

Test Plan:
1. Plain pipeline:
   - Stimulus: add x5 (PC=0x100), Data_rs1=7, Data_rs2=9.
   - Required: next cycle ID_EX_Valid=1, ID_EX_PC=0x100, Data 7/9, PC_Write=1.
2. Load-use:
   - Stimulus: lw x6 in EX (MemRead=1, Rd=6), ID has add using rs1=6.
   - Required: PC_Write=IF_ID_Write=0 for 1 cycle, one bubble (Valid=0, Ctrl=0), Hz_State=1, then the add is captured.
3. Load-use suppressed:
   - Stimulus: same as 2 with Uses_RS1=0; separately, with Rd=0.
   - Required: no stall.
4. Flush vs LU:
   - Stimulus: Flush=1 in the same cycle as LU.
   - Required: PC_Write=1, bubble loaded, Hz_State=0.
5. Freeze with pending flush:
   - Stimulus: Stall_in=1 for 3 cycles with Flush pulsed on the 2nd.
   - Required: outputs unchanged and Hz_State=2 during the freeze; first cycle after, a bubble is loaded; with ID_EX_PERF_CNT_EN, Perf_Flushes=1 and Perf_Freeze=3.
6. Reset mid-operation:
   - Stimulus: rst=1 during HOLD with pending=1.
   - Required: all outputs 0, state RUN; the next instruction is captured normally with no stale flush.
